// File: rtl/hdc_pkg.sv
// Shared encodings for the HDC seizure-detection datapath (training and inference).
package hdc_pkg;

  localparam int DIMENSIONS_DEFAULT  = 10000;
  localparam int MAX_SAMPLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    OP_ACC      = 2'd0,
    OP_FINALIZE = 2'd1,
    OP_CLEAR    = 2'd2
  } op_e;

  localparam logic LABEL_NONSEIZURE = 1'b0;
  localparam logic LABEL_SEIZURE    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } trainer_state_e;

endpackage

// File: rtl/bundle_counter_bank.sv
// Per-dimension set-bit counters for one class, with a majority compare at the addressed index.
module bundle_counter_bank #(
  parameter int DIMENSIONS = 8,
  parameter int CW         = 2,
  parameter int IW         = 3
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [IW-1:0] idx,
  input  logic          inc,
  input  logic          clr,
  input  logic [CW-1:0] n_total,
  output logic          above_half
);

  logic [CW-1:0] cnt [DIMENSIONS];
  logic [CW-1:0] rd;

  assign rd = cnt[idx];

  // 2*cnt > n evaluated in CW+1 bits so the doubled count cannot wrap; ties give 0.
  assign above_half = ({rd, 1'b0} > {1'b0, n_total});

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DIMENSIONS; i++) cnt[i] <= '0;
    end else if (clr) begin
      cnt[idx] <= '0;
    end else if (inc) begin
      cnt[idx] <= rd + CW'(1);
    end
  end

endmodule

// File: rtl/class_trainer.sv
// Bit-serial trainer: bundles labelled hypervectors into non-seizure/seizure prototypes.
// Handshake: en is sampled only while done=1; an accepted op holds done=0 for DIMENSIONS+1 cycles.
module class_trainer
  import hdc_pkg::*;
#(
  parameter int  DIMENSIONS  = DIMENSIONS_DEFAULT,
  parameter int  MAX_SAMPLES = MAX_SAMPLES_DEFAULT,
  localparam int CW          = $clog2(MAX_SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [1:0]            op,
  input  logic                  label,
  input  logic [DIMENSIONS-1:0] hv_train,
  output logic                  done,
  output logic                  overflow,
  output logic [CW-1:0]         n_nonseizure,
  output logic [CW-1:0]         n_seizure,
  output logic [DIMENSIONS-1:0] hv_nonseizure,
  output logic [DIMENSIONS-1:0] hv_seizure,
  output trainer_state_e        state_dbg
);

  localparam int IW = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;
  localparam int DW = $clog2(DIMENSIONS + 1);
  localparam logic [DW-1:0] D_END = DW'(DIMENSIONS);
  localparam logic [CW-1:0] N_MAX = CW'(MAX_SAMPLES);

  trainer_state_e state;
  op_e            op_q;
  logic           label_q;
  logic [DW-1:0]  d;
  logic [IW-1:0]  idx;
  logic           processing;
  logic           hv_bit;
  logic           class_full;
  logic           acc_ok;
  logic           clr_bit;
  logic           above_ns;
  logic           above_sz;

  assign state_dbg  = state;
  assign idx        = d[IW-1:0];
  assign processing = (state == ST_BUSY) && (d != D_END);
  assign hv_bit     = processing ? hv_train[idx] : 1'b0;
  assign class_full = (label_q == LABEL_SEIZURE) ? (n_seizure == N_MAX) : (n_nonseizure == N_MAX);
  assign acc_ok     = processing && (op_q == OP_ACC) && !class_full && hv_bit;
  assign clr_bit    = processing && (op_q == OP_CLEAR);

  bundle_counter_bank #(.DIMENSIONS(DIMENSIONS), .CW(CW), .IW(IW)) u_bank_ns (
    .clk        (clk),
    .nrst       (nrst),
    .idx        (idx),
    .inc        (acc_ok && (label_q == LABEL_NONSEIZURE)),
    .clr        (clr_bit),
    .n_total    (n_nonseizure),
    .above_half (above_ns)
  );

  bundle_counter_bank #(.DIMENSIONS(DIMENSIONS), .CW(CW), .IW(IW)) u_bank_sz (
    .clk        (clk),
    .nrst       (nrst),
    .idx        (idx),
    .inc        (acc_ok && (label_q == LABEL_SEIZURE)),
    .clr        (clr_bit),
    .n_total    (n_seizure),
    .above_half (above_sz)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= ST_IDLE;
      op_q          <= OP_ACC;
      label_q       <= LABEL_NONSEIZURE;
      d             <= '0;
      done          <= 1'b1;
      overflow      <= 1'b0;
      n_nonseizure  <= '0;
      n_seizure     <= '0;
      hv_nonseizure <= '0;
      hv_seizure    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && (op != 2'd3)) begin
            op_q    <= op_e'(op);
            label_q <= label;
            d       <= '0;
            done    <= 1'b0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (d == D_END) begin
            done  <= 1'b1;
            state <= ST_IDLE;
            d     <= '0;
            case (op_q)
              OP_ACC: begin
                // n is stable during BUSY, so class_full here matches the per-bit decision.
                if (class_full) overflow <= 1'b1;
                else if (label_q == LABEL_SEIZURE) n_seizure <= n_seizure + CW'(1);
                else n_nonseizure <= n_nonseizure + CW'(1);
              end
              OP_CLEAR: begin
                overflow      <= 1'b0;
                n_nonseizure  <= '0;
                n_seizure     <= '0;
                hv_nonseizure <= '0;
                hv_seizure    <= '0;
              end
              default: ;
            endcase
          end else begin
            d <= d + DW'(1);
            if (op_q == OP_FINALIZE) begin
              hv_nonseizure[idx] <= above_ns;
              hv_seizure[idx]    <= above_sz;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
